// File: rtl/snake_body_if.sv
// Handshake bundle between the game controller and one snake_body instance.
// The controller side is the master; snake_body is the slave.
interface snake_body_if #(
    parameter int max_len         = 15,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4
);
    logic                         step;
    logic [1:0]                   dir_in;
    logic                         dir_valid;
    logic                         grow;
    logic                         stop;
    logic [max_len*num_len-1:0]   snake;
    logic [max_len_bit_len-1:0]   len;
    logic [1:0]                   dir;
    logic                         moved;

    modport master (
        output step, dir_in, dir_valid, grow, stop,
        input  snake, len, dir, moved
    );

    modport slave (
        input  step, dir_in, dir_valid, grow, stop,
        output snake, len, dir, moved
    );
endinterface

// File: rtl/snake_body.sv
// Per-player snake position store and mover: holds the segment coordinates
// and length, advances one cell per accepted game step, applies turns
// (reverse turns dropped) and growth (saturating at max_len), wrapping at
// the grid edges.
module snake_body #(
    parameter int max_len         = 15,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4,
    parameter int GRID_W          = 32,
    parameter int GRID_H          = 24,
    parameter int INIT_X          = 8,
    parameter int INIT_Y          = 12,
    parameter int INIT_LEN        = 3
) (
    input logic         clk,
    input logic         rst,
    snake_body_if.slave bus
);
    localparam int CW = num_len / 2;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef logic [num_len-1:0] seg_t;

    seg_t                       seg_q [max_len];
    seg_t                       seg_d [max_len];
    logic [max_len_bit_len-1:0] len_q, len_d;
    dir_e                       dir_q, dir_d;
    dir_e                       next_dir_q, next_dir_d;
    logic                       grow_pend_q, grow_pend_d;
    logic                       moved_q, moved_d;

    logic                       accepted;
    logic                       dir_legal;
    dir_e                       eff_dir;
    logic [CW-1:0]              head_x, head_y;
    logic [CW-1:0]              new_x, new_y;

    // Decide whether this cycle moves and which direction the move uses.
    always_comb begin
        accepted  = bus.step & ~bus.stop;
        // Reverse pairs (0,1) and (2,3) differ only in bit 0.
        dir_legal = bus.dir_valid & ((bus.dir_in ^ 2'(dir_q)) != 2'b01);
        eff_dir   = dir_legal ? dir_e'(bus.dir_in) : next_dir_q;
        // The latched request is always the last legal one, which is exactly
        // the effective direction seen this cycle.
        next_dir_d = eff_dir;
    end

    // Compute the new head cell with wrap-around modulo the grid size.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        head_x = seg_q[0][num_len-1:CW];
        head_y = seg_q[0][CW-1:0];
        new_x  = head_x;
        new_y  = head_y;
        unique case (eff_dir)
            DIR_UP:    new_y = (head_y == '0) ? CW'(GRID_H - 1) : head_y - CW'(1);
            DIR_DOWN:  new_y = (head_y == CW'(GRID_H - 1)) ? '0 : head_y + CW'(1);
            DIR_LEFT:  new_x = (head_x == '0) ? CW'(GRID_W - 1) : head_x - CW'(1);
            DIR_RIGHT: new_x = (head_x == CW'(GRID_W - 1)) ? '0 : head_x + CW'(1);
            default:   ;
        endcase
    end

    // Next-state for body, length, direction, pending growth and move pulse.
    always_comb begin
        seg_d[0] = accepted ? {new_x, new_y} : seg_q[0];
        for (int i = 1; i < max_len; i++) begin
            seg_d[i] = accepted ? seg_q[i-1] : seg_q[i];
        end
        dir_d       = accepted ? eff_dir : dir_q;
        len_d       = len_q;
        if (accepted && (grow_pend_q | bus.grow) &&
            (len_q < max_len_bit_len'(max_len))) begin
            len_d = len_q + max_len_bit_len'(1);
        end
        // An accepted step consumes any growth, even when length is saturated.
        grow_pend_d = accepted ? 1'b0 : (grow_pend_q | bus.grow);
        moved_d     = accepted;
    end

    // State registers with asynchronous return to the starting snake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the segment array is a small register file that must start
            // as a straight line, so every slot is reset, not just len of them.
            for (int i = 0; i < max_len; i++) begin
                seg_q[i] <= {CW'(INIT_X - i), CW'(INIT_Y)};
            end
            len_q       <= max_len_bit_len'(INIT_LEN);
            dir_q       <= DIR_RIGHT;
            next_dir_q  <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, which the shift chain relies on.
            seg_q       <= seg_d;
            len_q       <= len_d;
            dir_q       <= dir_d;
            next_dir_q  <= next_dir_d;
            grow_pend_q <= grow_pend_d;
            moved_q     <= moved_d;
        end
    end

    // Pack the segment slots onto the output bus; head in the low slot.
    always_comb begin
        bus.snake = '0;
        for (int i = 0; i < max_len; i++) begin
            bus.snake[i*num_len +: num_len] = seg_q[i];
        end
        bus.len   = len_q;
        bus.dir   = 2'(dir_q);
        bus.moved = moved_q;
    end
endmodule
